// File: rtl/button_duty_stepper_if.sv
// Board push-buttons in, PWM duty values and step strobes out, for button_duty_stepper.
interface button_duty_stepper_if #(
  parameter int unsigned WIDTH = 6
);
  logic             Bt_Up;
  logic             Bt_Down;
  logic             Bt_Left;
  logic             Bt_Right;
  logic             Bt_Center;
  logic [WIDTH-1:0] Duty_X;
  logic [WIDTH-1:0] Duty_Y;
  logic             Step_X;
  logic             Step_Y;

  modport master (
    output Bt_Up, Bt_Down, Bt_Left, Bt_Right, Bt_Center,
    input  Duty_X, Duty_Y, Step_X, Step_Y
  );

  modport slave (
    input  Bt_Up, Bt_Down, Bt_Left, Bt_Right, Bt_Center,
    output Duty_X, Duty_Y, Step_X, Step_Y
  );
endinterface

// File: rtl/button_duty_stepper.sv
// Steps two PWM duty registers from debounced push-buttons, with hold-to-repeat,
// saturate/wrap arithmetic and a centre button that reloads both axes.
module button_duty_stepper #(
  parameter int unsigned WIDTH           = 6,
  parameter int unsigned STEP            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 1000000,
  parameter int unsigned REPEAT_RATE     = 250000,
  parameter bit          WRAP            = 1'b0,
  parameter int unsigned CENTER_X        = 2 ** (WIDTH - 1),
  parameter int unsigned CENTER_Y        = 2 ** (WIDTH - 1)
) (
  input logic                  Clk,
  input logic                  Rst,
  button_duty_stepper_if.slave bus
);

  localparam int unsigned NUM_BTN    = 5;
  localparam int unsigned BTN_UP     = 0;
  localparam int unsigned BTN_DOWN   = 1;
  localparam int unsigned BTN_LEFT   = 2;
  localparam int unsigned BTN_RIGHT  = 3;
  localparam int unsigned BTN_CENTER = 4;

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);
  localparam logic [WIDTH:0]   STEP_EXT   = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0]   DUTY_MAX   = {1'b0, {WIDTH{1'b1}}};

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} rpt_state_t;

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] db;
  logic [3:0]         req;
  logic               center_q;
  logic               center_rise;
  logic [WIDTH-1:0]   duty_x;
  logic [WIDTH-1:0]   duty_y;
  logic               step_x;
  logic               step_y;

  assign raw = {bus.Bt_Center, bus.Bt_Right, bus.Bt_Left, bus.Bt_Down, bus.Bt_Up};

  // Synchroniser and debouncer: db follows the synchronised level only after
  // DEBOUNCE_CYCLES consecutive differing samples; any agreeing sample restarts the count.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    logic [1:0]      sync_q;
    logic            db_q;
    logic [DB_W-1:0] db_cnt;

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, which is what makes the shift chain work.
    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        sync_q <= '0;
        db_q   <= 1'b0;
        db_cnt <= '0;
      end else begin
        sync_q <= {sync_q[0], raw[i]};
        if (sync_q[1] == db_q) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          db_q   <= sync_q[1];
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end
    end

    assign db[i] = db_q;
  end

  // Hold-to-repeat FSM per direction button; a step is requested on the press
  // itself, after REPEAT_DELAY cycles, then every REPEAT_RATE cycles.
  for (genvar i = 0; i < 4; i++) begin : g_dir
    rpt_state_t       state;
    logic [RPT_W-1:0] cnt;

    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else if (!db[i]) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_DELAY;
            cnt   <= '0;
          end
          ST_DELAY: begin
            if (cnt == DELAY_LAST) begin
              state <= ST_REPEAT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + RPT_W'(1);
            end
          end
          ST_REPEAT: begin
            cnt <= (cnt == RATE_LAST) ? '0 : cnt + RPT_W'(1);
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign req[i] = db[i] && ((state == ST_IDLE) ||
                              ((state == ST_DELAY)  && (cnt == DELAY_LAST)) ||
                              ((state == ST_REPEAT) && (cnt == RATE_LAST)));
  end

  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] d);
    logic [WIDTH:0] sum;
    sum = {1'b0, d} + STEP_EXT;
    if (!WRAP && (sum > DUTY_MAX)) return DUTY_MAX[WIDTH-1:0];
    return sum[WIDTH-1:0];
  endfunction

  // The extra top bit of the difference is the borrow, i.e. d < STEP.
  function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] d);
    logic [WIDTH:0] diff;
    diff = {1'b0, d} - STEP_EXT;
    if (!WRAP && diff[WIDTH]) return '0;
    return diff[WIDTH-1:0];
  endfunction

  assign center_rise = db[BTN_CENTER] && !center_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      duty_x   <= WIDTH'(CENTER_X);
      duty_y   <= WIDTH'(CENTER_Y);
      step_x   <= 1'b0;
      step_y   <= 1'b0;
      center_q <= 1'b0;
    end else begin
      center_q <= db[BTN_CENTER];
      // NOTE: strobes default low each cycle so a step pulse never lasts past its update.
      step_x   <= 1'b0;
      step_y   <= 1'b0;
      if (center_rise) begin
        duty_x <= WIDTH'(CENTER_X);
        duty_y <= WIDTH'(CENTER_Y);
        step_x <= 1'b1;
        step_y <= 1'b1;
      end else begin
        if (req[BTN_RIGHT] != req[BTN_LEFT]) begin
          duty_x <= req[BTN_RIGHT] ? step_up(duty_x) : step_down(duty_x);
          step_x <= 1'b1;
        end
        if (req[BTN_UP] != req[BTN_DOWN]) begin
          duty_y <= req[BTN_UP] ? step_up(duty_y) : step_down(duty_y);
          step_y <= 1'b1;
        end
      end
    end
  end

  assign bus.Duty_X = duty_x;
  assign bus.Duty_Y = duty_y;
  assign bus.Step_X = step_x;
  assign bus.Step_Y = step_y;

endmodule

// File: tb/tb_button_duty_stepper.sv
// Directed bench: one main stepper plus two instances centred at X=62 to show
// saturate versus wrap behaviour at the top of the range.
module tb_button_duty_stepper;
  localparam int unsigned WIDTH = 6;

  logic Clk;
  logic Rst;
  logic bt_up, bt_down, bt_left, bt_right, bt_center;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  button_duty_stepper_if #(.WIDTH(WIDTH)) bus ();
  button_duty_stepper_if #(.WIDTH(WIDTH)) bus_sat ();
  button_duty_stepper_if #(.WIDTH(WIDTH)) bus_wrap ();

  assign bus.Bt_Up = bt_up;           assign bus.Bt_Down = bt_down;
  assign bus.Bt_Left = bt_left;       assign bus.Bt_Right = bt_right;
  assign bus.Bt_Center = bt_center;
  assign bus_sat.Bt_Up = bt_up;       assign bus_sat.Bt_Down = bt_down;
  assign bus_sat.Bt_Left = bt_left;   assign bus_sat.Bt_Right = bt_right;
  assign bus_sat.Bt_Center = bt_center;
  assign bus_wrap.Bt_Up = bt_up;      assign bus_wrap.Bt_Down = bt_down;
  assign bus_wrap.Bt_Left = bt_left;  assign bus_wrap.Bt_Right = bt_right;
  assign bus_wrap.Bt_Center = bt_center;

  button_duty_stepper #(
    .WIDTH(WIDTH), .STEP(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_RATE(4),
    .WRAP(1'b0), .CENTER_X(32), .CENTER_Y(32)
  ) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  button_duty_stepper #(
    .WIDTH(WIDTH), .STEP(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_RATE(4),
    .WRAP(1'b0), .CENTER_X(62), .CENTER_Y(32)
  ) dut_sat (.Clk(Clk), .Rst(Rst), .bus(bus_sat));

  button_duty_stepper #(
    .WIDTH(WIDTH), .STEP(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_RATE(4),
    .WRAP(1'b1), .CENTER_X(62), .CENTER_Y(32)
  ) dut_wrap (.Clk(Clk), .Rst(Rst), .bus(bus_wrap));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_reset();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    {bt_up, bt_down, bt_left, bt_right, bt_center} = '0;
    repeat (3) tick();
    n_cmp++; if (bus.Duty_X !== 6'd32) begin n_err++; $display("FAIL reset_duty_x: got %0d want 32", bus.Duty_X); end
    n_cmp++; if (bus.Duty_Y !== 6'd32) begin n_err++; $display("FAIL reset_duty_y: got %0d want 32", bus.Duty_Y); end
    n_cmp++; if ({bus.Step_X, bus.Step_Y} !== 2'b00) begin n_err++; $display("FAIL reset_steps: got %b want 00", {bus.Step_X, bus.Step_Y}); end
    n_cmp++; if (bus_sat.Duty_X !== 6'd62) begin n_err++; $display("FAIL reset_sat_duty_x: got %0d want 62", bus_sat.Duty_X); end
    Rst = 1'b0;
    repeat (4) tick();
    n_cmp++; if ({bus.Duty_X, bus.Duty_Y, bus.Step_X, bus.Step_Y} !== {6'd32, 6'd32, 2'b00}) begin
      n_err++; $display("FAIL reset_idle: got x=%0d y=%0d sx=%b sy=%b want 32 32 0 0", bus.Duty_X, bus.Duty_Y, bus.Step_X, bus.Step_Y);
    end
  endtask

  task automatic test_clean_press();
    logic [5:0] exp_y;
    int unsigned extra;
    bt_up = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n == 6) bt_up = 1'b0;
      exp_y = (n >= 7) ? 6'd36 : 6'd32;
      n_cmp++; if (bus.Duty_Y !== exp_y) begin n_err++; $display("FAIL press_duty_y edge %0d: got %0d want %0d", n, bus.Duty_Y, exp_y); end
      n_cmp++; if (bus.Step_Y !== (n == 7)) begin n_err++; $display("FAIL press_step_y edge %0d: got %b want %b", n, bus.Step_Y, n == 7); end
    end
    extra = 0;
    repeat (12) begin tick(); if (bus.Step_Y === 1'b1) extra++; end
    n_cmp++; if (extra != 0) begin n_err++; $display("FAIL press_no_repeat: got %0d extra steps want 0", extra); end
    n_cmp++; if ({bus.Duty_X, bus.Duty_Y} !== {6'd32, 6'd36}) begin n_err++; $display("FAIL press_final: got x=%0d y=%0d want 32 36", bus.Duty_X, bus.Duty_Y); end
  endtask

  task automatic test_bounce();
    int unsigned steps;
    steps = 0;
    for (int k = 0; k < 10; k++) begin
      bt_right = (k % 2 == 0);
      repeat (2) begin tick(); if (bus.Step_X === 1'b1) steps++; end
    end
    n_cmp++; if (steps != 0) begin n_err++; $display("FAIL bounce_rejected: got %0d steps want 0", steps); end
    bt_right = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      tick();
      n_cmp++; if (bus.Step_X !== (n == 7)) begin n_err++; $display("FAIL bounce_step_x edge %0d: got %b want %b", n, bus.Step_X, n == 7); end
    end
    n_cmp++; if (bus.Duty_X !== 6'd36) begin n_err++; $display("FAIL bounce_duty_x: got %0d want 36", bus.Duty_X); end
    bt_right = 1'b0;
    steps = 0;
    repeat (15) begin tick(); if (bus.Step_X === 1'b1) steps++; end
    n_cmp++; if (steps != 0 || bus.Duty_X !== 6'd36) begin
      n_err++; $display("FAIL bounce_single_step: got %0d extra steps x=%0d want 0 steps x=36", steps, bus.Duty_X);
    end
  endtask

  task automatic test_auto_repeat();
    logic [5:0] exp_y;
    logic exp_s;
    int unsigned steps;
    pulse_reset();
    exp_y = 6'd32;
    steps = 0;
    bt_down = 1'b1;
    for (int n = 1; n <= 46; n++) begin
      tick();
      exp_s = (n == 7) || (n >= 15 && n <= 43 && ((n - 15) % 4 == 0));
      if (exp_s) exp_y = (exp_y < 6'd4) ? 6'd0 : exp_y - 6'd4;
      if (bus.Step_Y === 1'b1) steps++;
      n_cmp++; if (bus.Step_Y !== exp_s) begin n_err++; $display("FAIL repeat_step_y edge %0d: got %b want %b", n, bus.Step_Y, exp_s); end
      n_cmp++; if (bus.Duty_Y !== exp_y) begin n_err++; $display("FAIL repeat_duty_y edge %0d: got %0d want %0d", n, bus.Duty_Y, exp_y); end
    end
    n_cmp++; if (steps != 9) begin n_err++; $display("FAIL repeat_step_count: got %0d want 9", steps); end
    bt_down = 1'b0;
    repeat (12) tick();
    n_cmp++; if ({bus.Duty_X, bus.Duty_Y} !== {6'd32, 6'd0}) begin n_err++; $display("FAIL repeat_final: got x=%0d y=%0d want 32 0", bus.Duty_X, bus.Duty_Y); end
  endtask

  task automatic test_saturate_wrap();
    pulse_reset();
    bt_right = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      tick();
      if (n == 6) bt_right = 1'b0;
      if (n == 6) begin
        n_cmp++; if ({bus_sat.Duty_X, bus_wrap.Duty_X} !== {6'd62, 6'd62}) begin
          n_err++; $display("FAIL satwrap_before: got sat=%0d wrap=%0d want 62 62", bus_sat.Duty_X, bus_wrap.Duty_X);
        end
      end
    end
    n_cmp++; if (bus_sat.Duty_X !== 6'd63) begin n_err++; $display("FAIL saturate_top: got %0d want 63", bus_sat.Duty_X); end
    n_cmp++; if (bus_wrap.Duty_X !== 6'd2) begin n_err++; $display("FAIL wrap_top: got %0d want 2", bus_wrap.Duty_X); end
    n_cmp++; if (bus.Duty_X !== 6'd36) begin n_err++; $display("FAIL satwrap_main_x: got %0d want 36", bus.Duty_X); end
    n_cmp++; if ({bus_sat.Step_X, bus_wrap.Step_X} !== 2'b11) begin n_err++; $display("FAIL satwrap_steps: got %b want 11", {bus_sat.Step_X, bus_wrap.Step_X}); end
    repeat (12) tick();
  endtask

  task automatic test_opposing();
    int unsigned steps;
    steps = 0;
    bt_up = 1'b1;
    bt_down = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 6) begin bt_up = 1'b0; bt_down = 1'b0; end
      if (bus.Step_Y === 1'b1) steps++;
    end
    n_cmp++; if (steps != 0) begin n_err++; $display("FAIL opposing_step_y: got %0d steps want 0", steps); end
    n_cmp++; if ({bus.Duty_X, bus.Duty_Y} !== {6'd36, 6'd32}) begin n_err++; $display("FAIL opposing_duty: got x=%0d y=%0d want 36 32", bus.Duty_X, bus.Duty_Y); end
  endtask

  task automatic test_center();
    bt_up = 1'b1;
    bt_right = 1'b1;
    repeat (6) tick();
    bt_up = 1'b0;
    bt_right = 1'b0;
    tick();
    n_cmp++; if ({bus.Duty_X, bus.Duty_Y, bus.Step_X, bus.Step_Y} !== {6'd40, 6'd36, 2'b11}) begin
      n_err++; $display("FAIL concurrent_axes: got x=%0d y=%0d sx=%b sy=%b want 40 36 1 1", bus.Duty_X, bus.Duty_Y, bus.Step_X, bus.Step_Y);
    end
    repeat (12) tick();
    bt_left = 1'b1;
    bt_center = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      tick();
      if (n == 7) begin
        n_cmp++; if ({bus.Duty_X, bus.Duty_Y, bus.Step_X, bus.Step_Y} !== {6'd32, 6'd32, 2'b11}) begin
          n_err++; $display("FAIL center_override: got x=%0d y=%0d sx=%b sy=%b want 32 32 1 1", bus.Duty_X, bus.Duty_Y, bus.Step_X, bus.Step_Y);
        end
      end else if (n > 7 && n < 15) begin
        n_cmp++; if ({bus.Step_X, bus.Step_Y} !== 2'b00) begin n_err++; $display("FAIL center_quiet edge %0d: got %b want 00", n, {bus.Step_X, bus.Step_Y}); end
      end
    end
    n_cmp++; if ({bus.Duty_X, bus.Duty_Y, bus.Step_X, bus.Step_Y} !== {6'd28, 6'd32, 2'b10}) begin
      n_err++; $display("FAIL center_no_repeat: got x=%0d y=%0d sx=%b sy=%b want 28 32 1 0", bus.Duty_X, bus.Duty_Y, bus.Step_X, bus.Step_Y);
    end
    bt_left = 1'b0;
    bt_center = 1'b0;
    repeat (12) tick();
    n_cmp++; if ({bus.Duty_X, bus.Duty_Y} !== {6'd24, 6'd32}) begin n_err++; $display("FAIL center_release: got x=%0d y=%0d want 24 32", bus.Duty_X, bus.Duty_Y); end
  endtask

  task automatic test_async_reset();
    bt_right = 1'b1;
    repeat (21) tick();
    n_cmp++; if (bus.Duty_X !== 6'd36) begin n_err++; $display("FAIL pre_reset_x: got %0d want 36", bus.Duty_X); end
    @(posedge Clk);
    #3;
    Rst = 1'b1;
    #1;
    n_cmp++; if ({bus.Duty_X, bus.Step_X} !== {6'd32, 1'b0}) begin n_err++; $display("FAIL async_reset: got x=%0d sx=%b want 32 0", bus.Duty_X, bus.Step_X); end
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      tick();
      n_cmp++; if (bus.Step_X !== (n == 7)) begin n_err++; $display("FAIL post_reset_step edge %0d: got %b want %b", n, bus.Step_X, n == 7); end
    end
    n_cmp++; if (bus.Duty_X !== 6'd36) begin n_err++; $display("FAIL post_reset_x: got %0d want 36", bus.Duty_X); end
    bt_right = 1'b0;
    repeat (15) tick();
    n_cmp++; if (bus.Duty_X !== 6'd36) begin n_err++; $display("FAIL post_reset_final: got %0d want 36", bus.Duty_X); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_saturate_wrap();
    test_opposing();
    test_center();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
